// File: rtl/fa_exerciser.sv
// Self-checking stimulus/response sweeper for a 3-input full adder.
// Optional build macro FA_EXER_STOP_ON_FAIL_EN: halt the sweep on the first mismatch.
module fa_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic [2:0] o_stim,
    input  logic [1:0] i_resp,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_err_count,
    output logic [2:0] o_fail_vec,
    output logic       o_fail_seen
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_t;

    localparam logic [7:0] LastCnt = 8'(SETTLE_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_stim;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err;
    logic [2:0] r_fail_vec;
    logic       r_fail_seen;

    logic [1:0] w_exp;
    logic       w_mismatch;
    logic       w_finish;

    // Golden full-adder result: {sum, carry}
    always_comb begin
        w_exp[1] = r_stim[2] ^ r_stim[1] ^ r_stim[0];
        w_exp[0] = (r_stim[2] & r_stim[1]) | (r_stim[2] & r_stim[0]) | (r_stim[1] & r_stim[0]);
        w_mismatch = (i_resp != w_exp);
`ifdef FA_EXER_STOP_ON_FAIL_EN
        w_finish = w_mismatch || (r_stim == 3'd7);
`else
        w_finish = (r_stim == 3'd7);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= 8'd0;
            r_stim      <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= 4'd0;
            r_fail_vec  <= 3'd0;
            r_fail_seen <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_state     <= StDrive;
                        r_cnt       <= 8'd0;
                        r_stim      <= 3'd0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err       <= 4'd0;
                        r_fail_vec  <= 3'd0;
                        r_fail_seen <= 1'b0;
                    end
                end
                StDrive: begin
                    if (r_cnt == LastCnt) begin
                        r_cnt   <= 8'd0;
                        r_state <= StSample;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StSample: begin
                    if (w_mismatch) begin
                        r_err <= r_err + 4'd1;
                        if (!r_fail_seen) begin
                            r_fail_vec  <= r_stim;
                            r_fail_seen <= 1'b1;
                        end
                    end
                    if (w_finish) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= !w_mismatch && (r_err == 4'd0);
                    end else begin
                        r_stim  <= r_stim + 3'd1;
                        r_state <= StDrive;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_stim      = r_stim;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_err_count = r_err;
    assign o_fail_vec  = r_fail_vec;
    assign o_fail_seen = r_fail_seen;

endmodule

// File: tb/tb_fa_exerciser.sv
// Bench for fa_exerciser: table of adder fault models plus hand sequences for restart and reset.
module tb_fa_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start4, start1, sel, in_sample;
    int         mode;
    logic [1:0] resp4, resp1;
    logic [2:0] stim4, stim1, fvec4, fvec1;
    logic       busy4, busy1, done4, done1, pass4, pass1, fseen4, fseen1;
    logic [3:0] err4, err1;

    logic [2:0] m_stim, m_fvec;
    logic       m_busy, m_done, m_pass, m_fseen;
    logic [3:0] m_err;

    int checks = 0;
    int failures = 0;

    fa_exerciser #(.SETTLE_CYCLES(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .o_stim(stim4), .i_resp(resp4),
        .o_busy(busy4), .o_done(done4), .o_pass(pass4), .o_err_count(err4),
        .o_fail_vec(fvec4), .o_fail_seen(fseen4)
    );

    fa_exerciser #(.SETTLE_CYCLES(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .o_stim(stim1), .i_resp(resp1),
        .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_count(err1),
        .o_fail_vec(fvec1), .o_fail_seen(fseen1)
    );

    function automatic logic [1:0] golden(input logic [2:0] s);
        logic a, b, c;
        a = s[2]; b = s[1]; c = s[0];
        return {a ^ b ^ c, (a & b) | (a & c) | (b & c)};
    endfunction

    // 0 correct, 1 carry stuck-at-0, 2 sum inverted, 3 wrong except in the SAMPLE cycle
    function automatic logic [1:0] adder(input int m, input logic [2:0] s, input logic smp);
        logic [1:0] g;
        g = golden(s);
        case (m)
            1:       return {g[1], 1'b0};
            2:       return {~g[1], g[0]};
            3:       return smp ? g : ~g;
            default: return g;
        endcase
    endfunction

    always_comb begin
        resp4 = adder(mode, stim4, in_sample);
        resp1 = adder(mode, stim1, in_sample);
        m_stim  = sel ? stim1  : stim4;
        m_busy  = sel ? busy1  : busy4;
        m_done  = sel ? done1  : done4;
        m_pass  = sel ? pass1  : pass4;
        m_err   = sel ? err1   : err4;
        m_fvec  = sel ? fvec1  : fvec4;
        m_fseen = sel ? fseen1 : fseen4;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stim"}, int'(stim4), 0);
        chk({tag, "_busy"}, int'(busy4), 0);
        chk({tag, "_done"}, int'(done4), 0);
        chk({tag, "_pass"}, int'(pass4), 0);
        chk({tag, "_err"}, int'(err4), 0);
        chk({tag, "_fvec"}, int'(fvec4), 0);
        chk({tag, "_fseen"}, int'(fseen4), 0);
    endtask

    typedef struct {
        int mode; int settle; int err; int fvec; int pass; int fseen; int nvec;
    } vec_t;

    int exp_q[$];

    task automatic run(input vec_t v, input string tag);
        int k, e;
        sel = (v.settle == 1);
        mode = v.mode;
        in_sample = 1'b0;
        for (int i = 0; i < v.nvec * (v.settle + 1); i++) exp_q.push_back(i / (v.settle + 1));
        @(negedge clk);
        if (sel) start1 = 1'b1; else start4 = 1'b1;
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk({tag, "_busy"}, int'(m_busy), 1);
            chk({tag, "_stim"}, int'(m_stim), e);
            chk({tag, "_done_early"}, int'(m_done), 0);
            start4 = 1'b0;
            start1 = 1'b0;
            in_sample = ((k % (v.settle + 1)) == v.settle);
            k++;
        end
        @(negedge clk);
        in_sample = 1'b0;
        chk({tag, "_busy_end"}, int'(m_busy), 0);
        chk({tag, "_done"}, int'(m_done), 1);
        chk({tag, "_pass"}, int'(m_pass), v.pass);
        chk({tag, "_err"}, int'(m_err), v.err);
        chk({tag, "_fvec"}, int'(m_fvec), v.fvec);
        chk({tag, "_fseen"}, int'(m_fseen), v.fseen);
        chk({tag, "_stim_final"}, int'(m_stim), v.nvec - 1);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_timeout"}, int'(done4), 1);
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{0, 4, 0, 0, 1, 0, 8};
`ifdef FA_EXER_STOP_ON_FAIL_EN
        tbl[1] = '{1, 4, 1, 3, 0, 1, 4};
        tbl[2] = '{2, 4, 1, 0, 0, 1, 1};
        tbl[5] = '{1, 1, 1, 3, 0, 1, 4};
`else
        tbl[1] = '{1, 4, 4, 3, 0, 1, 8};
        tbl[2] = '{2, 4, 8, 0, 0, 1, 8};
        tbl[5] = '{1, 1, 4, 3, 0, 1, 8};
`endif
        tbl[3] = '{3, 4, 0, 0, 1, 0, 8};
        tbl[4] = '{0, 1, 0, 0, 1, 0, 8};

        rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0; sel = 1'b0; mode = 0; in_sample = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        chk("reset_busy1", int'(busy1), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_zero("idle_nostart");

        for (int i = 0; i < 6; i++) run(tbl[i], $sformatf("vec%0d", i));

        // start held high from DONE: one cycle of done between back-to-back runs
        run(tbl[1], "pre_held");
        sel = 1'b0; mode = 0;
        start4 = 1'b1;
        @(negedge clk);
        chk("held_busy", int'(busy4), 1);
        chk("held_err_clr", int'(err4), 0);
        chk("held_fseen_clr", int'(fseen4), 0);
        chk("held_done_clr", int'(done4), 0);
        chk("held_stim0", int'(stim4), 0);
        wait_done("held_run1");
        @(negedge clk);
        chk("held_rerun_busy", int'(busy4), 1);
        chk("held_rerun_done", int'(done4), 0);
        start4 = 1'b0;
        wait_done("held_run2");
        chk("held_pass", int'(pass4), 1);

        // reset mid-run
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (14) @(negedge clk);
        chk("midrun_busy", int'(busy4), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        repeat (3) @(negedge clk);
        chk_zero("rst_hold");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_zero("rst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fa_exerciser.md
Name: fa_exerciser

Overview:
- Self-checking stimulus and response block for the 3-input full adder board wrapper.
- It is the driving end of the adder's interface. It generates the adder's input vector (a, b, cin), samples the returned (sum, carry) and compares against the golden value.
- Sweeps all 8 input combinations per run and reports pass/fail, error count and first failing vector, so the adder can be checked on-board without manual switch toggling.

Parameters:
- SETTLE_CYCLES, 4, clock cycles stim is held before resp is sampled; legal range 1..255; 0 is rejected by an elaboration-time check.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled each cycle; begins a run when in IDLE or DONE.
- stim  output  3  vector to adder: stim[2]=a, stim[1]=b, stim[0]=cin.
- resp  input  2  adder result: resp[1]=sum, resp[0]=carry; treated as asynchronous to the FSM only through the settle delay.
- busy  output  1  high from first DRIVE cycle through last SAMPLE cycle.
- done  output  1  high in DONE state, held until next run starts or reset.
- pass  output  1  valid when done=1; 1 iff err_count==0.
- err_count  output  4  number of mismatching vectors in current/last run (0..8).
- fail_vec  output  3  first mismatching stim value of the run; 0 when none.
- fail_seen  output  1  high once any mismatch is recorded in the run.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_seen=0; settle counter=0.
- Golden model: exp_sum = a^b^cin; exp_carry = (a&b)|(a&cin)|(b&cin).
- FSM states:
  - IDLE: wait for start=1. Next cycle enters DRIVE with stim=0 and clears err_count, fail_vec, fail_seen, done, pass.
  - DRIVE: stim held constant. Counter counts SETTLE_CYCLES cycles, then the FSM goes to SAMPLE.
  - SAMPLE (1 cycle): compare resp with golden value for the current stim. On mismatch: err_count+=1; if fail_seen=0, then fail_vec<=stim and fail_seen<=1.
    - If stim==7, go to DONE.
    - Else stim<=stim+1 and go to DRIVE.
  - DONE: done=1, pass=(err_count==0), busy=0, stim holds 7. start=1 restarts exactly as from IDLE.
- Timing: one run = 8*(SETTLE_CYCLES+1) cycles of busy. done rises the cycle after the 8th SAMPLE.
- start while busy is ignored. A mid-run start does not restart the sweep.
- stim never wraps within a run. The 7->0 transition happens only on a restart.
- err_count saturates naturally at 8 and cannot overflow 4 bits.
- Reset asserted mid-run aborts immediately to reset values. No partial result is retained.
- The sampled resp value is used only in the SAMPLE cycle. No other cycle's resp affects outputs.

Optional Feature:
- Macro FA_EXER_STOP_ON_FAIL_EN.
- Defined: on the first mismatch in SAMPLE, go directly to DONE. stim stays at the failing vector so LEDs show the offending input. err_count=1, pass=0.
- Undefined: always sweep all 8 vectors and count every mismatch.

Test Plan:
- Correct adder model on resp, SETTLE_CYCLES=4, start pulse -> busy high 40 cycles; done=1, pass=1, err_count=0, fail_seen=0, fail_vec=0.
- Adder model with carry stuck-at-0 -> mismatches at stim 3,5,6,7; err_count=4, fail_vec=3, pass=0.
  - With FA_EXER_STOP_ON_FAIL_EN: done after 4th SAMPLE, stim=3, err_count=1.
- Sum inverted -> err_count=8, fail_vec=0, pass=0.
- start held high continuously from IDLE -> exactly one run per DONE visit. Re-run starts the cycle after DONE and clears err_count to 0.
- rst_n pulled low at cycle 15 of a run, released 3 cycles later -> all outputs 0 during and after reset; no run until a new start.
- SETTLE_CYCLES=1 with correct model -> busy 16 cycles, stim steps 0..7 every 2 cycles, pass=1.
